// File: rtl/ttt_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the tic-tac-toe board controller: cell and status
// codes, the controller state enum and the win-line table.
package ttt_pkg;

    // Cell contents as stored in the packed board
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] X     = 2'b01;
    localparam logic [1:0] O     = 2'b10;

    // Game status codes; these drive the display mux select directly
    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] XWIN  = 2'b01;
    localparam logic [1:0] OWIN  = 2'b10;
    localparam logic [1:0] DRAW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OVER = 2'd2
    } state_t;

    // Cell indices of each win line: rows, columns, diagonal, anti-diagonal
    localparam logic [3:0] LINE_CELLS [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Read one 2-bit cell out of the packed board; indices above 8 read as empty
    function automatic logic [1:0] get_cell(input logic [17:0] brd, input logic [3:0] idx);
        logic [1:0] c;
        c = EMPTY;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) begin
                c = brd[2*i +: 2];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
`timescale 1ns/1ps
// Combinational check of one win line: returns the owning player's cell code
// when all three cells match and are occupied, otherwise EMPTY.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    output logic [1:0] winner
);

    // Three equal, non-empty cells mean the line is owned by that player
    always_comb begin
        winner = EMPTY;
        if ((cell_a != EMPTY) && (cell_a == cell_b) && (cell_b == cell_c)) begin
            winner = cell_a;
        end
    end

endmodule

// File: rtl/ttt_board_ctrl.sv
`timescale 1ns/1ps
// Tic-tac-toe game-state controller. Accepts moves over valid/ready, rejects
// illegal ones, holds the board and scans the eight win lines one per cycle
// after every legal move before publishing the game status.
// Optional feature: define TTT_MOVE_CNT_EN to expose the move counter on move_cnt.
module ttt_board_ctrl
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        mv_valid,
    input  logic [3:0]  mv_cell,
    output logic        mv_ready,
    output logic        mv_ack,
    output logic        mv_err,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  status
`ifdef TTT_MOVE_CNT_EN
    ,
    output logic [3:0]  move_cnt
`endif
);

    state_t      state_q,  state_d;
    logic [17:0] board_q,  board_d;
    logic        turn_q,   turn_d;
    logic [1:0]  status_q, status_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [2:0]  line_q,   line_d;
    logic [1:0]  win_q,    win_d;
    logic        ack_q,    ack_d;
    logic        err_q,    err_d;

    logic [1:0]  line_a, line_b, line_c;
    logic [1:0]  line_win;
    logic [1:0]  found;
    logic [1:0]  target;
    logic [1:0]  mark;
    logic        legal;

    // Fetch the three cells of the line currently under scan
    always_comb begin
        line_a = get_cell(board_q, LINE_CELLS[line_q][0]);
        line_b = get_cell(board_q, LINE_CELLS[line_q][1]);
        line_c = get_cell(board_q, LINE_CELLS[line_q][2]);
    end

    ttt_line_check u_line_check (
        .cell_a (line_a),
        .cell_b (line_b),
        .cell_c (line_c),
        .winner (line_win)
    );

    // Move legality: in-range cell that is still empty (state checked in the FSM)
    always_comb begin
        target = get_cell(board_q, mv_cell);
        mark   = turn_q ? O : X;
        legal  = (mv_cell <= 4'd8) && (target == EMPTY);
    end

    // Next-state logic: move handling, sequential line scan and game clear
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        win_d    = win_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        found    = (win_q != EMPTY) ? win_q : line_win;

        if (new_game) begin
            state_d  = IDLE;
            board_d  = '0;
            turn_d   = FIRST_PLAYER;
            status_d = RUN;
            cnt_d    = 4'd0;
            line_d   = 3'd0;
            win_d    = EMPTY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mv_valid) begin
                        if (legal) begin
                            for (int i = 0; i < 9; i++) begin
                                if (mv_cell == 4'(i)) begin
                                    board_d[2*i +: 2] = mark;
                                end
                            end
                            cnt_d   = cnt_q + 4'd1;
                            line_d  = 3'd0;
                            win_d   = EMPTY;
                            ack_d   = 1'b1;
                            state_d = SCAN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    win_d = found;
                    if (line_q == 3'd7) begin
                        if (found != EMPTY) begin
                            status_d = (found == X) ? XWIN : OWIN;
                            state_d  = OVER;
                        end else if (cnt_q == 4'd9) begin
                            status_d = DRAW;
                            state_d  = OVER;
                        end else begin
                            turn_d  = ~turn_q;
                            state_d = IDLE;
                        end
                    end else begin
                        line_d = line_q + 3'd1;
                    end
                end
                OVER: begin
                    if (mv_valid) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset to an empty board
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            board_q  <= '0;
            turn_q   <= FIRST_PLAYER;
            status_q <= RUN;
            cnt_q    <= 4'd0;
            line_q   <= 3'd0;
            win_q    <= EMPTY;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            win_q    <= win_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign mv_ready = ((state_q == IDLE) || (state_q == OVER)) && !new_game && !rst;
    assign mv_ack   = ack_q;
    assign mv_err   = err_q;
    assign board    = board_q;
    assign turn     = turn_q;
    assign status   = status_q;
`ifdef TTT_MOVE_CNT_EN
    assign move_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ttt_board_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for ttt_board_ctrl: directed game scenarios plus random
// moves, compared every cycle against a game-level model of the board.
module tb_ttt_board_ctrl;

    localparam logic FP = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic        mv_valid;
    logic [3:0]  mv_cell;
    logic        mv_ready;
    logic        mv_ack;
    logic        mv_err;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  status;
`ifdef TTT_MOVE_CNT_EN
    logic [3:0]  move_cnt;
`endif

    ttt_board_ctrl #(.FIRST_PLAYER(FP)) dut (
        .clk      (clk),
        .rst      (rst),
        .new_game (new_game),
        .mv_valid (mv_valid),
        .mv_cell  (mv_cell),
        .mv_ready (mv_ready),
        .mv_ack   (mv_ack),
        .mv_err   (mv_err),
        .board    (board),
        .turn     (turn),
        .status   (status)
`ifdef TTT_MOVE_CNT_EN
        ,
        .move_cnt (move_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Game-level model: board as 9 ints (0 empty, 1 X, 2 O), whose turn,
    // result, moves played, and how many scan cycles remain before a result
    int mdl_board [9];
    int mdl_turn;
    int mdl_status;
    int mdl_cnt;
    int mdl_busy;
    int mdl_w;
    bit mdl_ack;
    bit mdl_err;

    int lines [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic int winner_of();
        for (int l = 0; l < 8; l++) begin
            if (mdl_board[lines[l][0]] != 0 &&
                mdl_board[lines[l][0]] == mdl_board[lines[l][1]] &&
                mdl_board[lines[l][1]] == mdl_board[lines[l][2]])
                return mdl_board[lines[l][0]];
        end
        return 0;
    endfunction

    function automatic logic [17:0] mdl_packed();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mdl_board[i]);
        return b;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 9; i++) mdl_board[i] = 0;
        mdl_turn   = int'(FP);
        mdl_status = 0;
        mdl_cnt    = 0;
        mdl_busy   = 0;
        mdl_ack    = 1'b0;
        mdl_err    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the game model on each clock edge from the sampled inputs
    always @(posedge clk) begin
        if (rst || new_game) begin
            mdl_clear();
        end else begin
            mdl_ack = 1'b0;
            mdl_err = 1'b0;
            if (mdl_busy > 0) begin
                mdl_busy--;
                if (mdl_busy == 0) begin
                    mdl_w = winner_of();
                    if (mdl_w != 0)        mdl_status = mdl_w;
                    else if (mdl_cnt == 9) mdl_status = 3;
                    else                   mdl_turn   = 1 - mdl_turn;
                end
            end else if (mv_valid) begin
                if (mdl_status == 0 && mv_cell <= 4'd8 && mdl_board[int'(mv_cell)] == 0) begin
                    mdl_board[int'(mv_cell)] = mdl_turn + 1;
                    mdl_cnt++;
                    mdl_ack  = 1'b1;
                    mdl_busy = 8;
                end else begin
                    mdl_err = 1'b1;
                end
            end
        end
    end

    // Compare every DUT output to the model mid-cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("board",    32'(board),    32'(mdl_packed()));
            checkOutput("turn",     32'(turn),     32'(mdl_turn));
            checkOutput("status",   32'(status),   32'(mdl_status));
            checkOutput("mv_ack",   32'(mv_ack),   32'(mdl_ack));
            checkOutput("mv_err",   32'(mv_err),   32'(mdl_err));
            checkOutput("mv_ready", 32'(mv_ready), 32'((mdl_busy == 0) && !new_game && !rst));
`ifdef TTT_MOVE_CNT_EN
            checkOutput("move_cnt", 32'(move_cnt), 32'(mdl_cnt));
`endif
        end
    end

    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic ng, input logic r);
        @(posedge clk);
        #2;
        mv_valid = v;
        mv_cell  = c;
        new_game = ng;
        rst      = r;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (mdl_busy != 0 && n < 20) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
            n++;
        end
        if (mdl_busy != 0) checkOutput("idle_timeout", 32'(mdl_busy), 32'd0);
    endtask

    // Offer one move for one cycle once the controller is idle; returns with
    // inputs quiet, just before the cycle after the handshake
    task automatic doMove(input logic [3:0] c);
        waitIdle();
        applyStimulus(1'b1, c, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic newGame();
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic playSeq(input int seq [9], input int n);
        for (int i = 0; i < n; i++) doMove(4'(seq[i]));
        waitIdle();
        @(negedge clk);
    endtask

    int seq_win  [9] = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
    int seq_draw [9] = '{4, 0, 2, 6, 3, 5, 8, 1, 7};
    int seq_nine [9] = '{0, 1, 4, 2, 5, 3, 7, 6, 8};

    initial begin
        rst = 1'b1; new_game = 1'b0; mv_valid = 1'b0; mv_cell = 4'd0;
        mdl_clear();
        @(posedge clk);
        #1 cmp_en = 1'b1;

        // Reset values while rst is held
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_ready", 32'(mv_ready), 32'd0);
        checkOutput("rst_board", 32'(board), 32'd0);
        checkOutput("rst_turn", 32'(turn), 32'(FP));
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(mv_ready), 32'd1);

        // First move X at centre, then scan timing
        doMove(4'd4);
        @(negedge clk);
        checkOutput("ack_t1", 32'(mv_ack), 32'd1);
        checkOutput("board_t1", 32'(board), 32'h00100);
        checkOutput("mdl_board4", 32'(mdl_board[4]), 32'd1);
        repeat (7) @(negedge clk);
        checkOutput("ready_t8", 32'(mv_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_t9", 32'(mv_ready), 32'd1);
        checkOutput("turn_t9", 32'(turn), 32'd1);
        checkOutput("status_t9", 32'(status), 32'd0);

        // O onto occupied centre, then out-of-range cell
        doMove(4'd4);
        @(negedge clk);
        checkOutput("err_occupied", 32'(mv_err), 32'd1);
        checkOutput("board_kept", 32'(board), 32'h00100);
        checkOutput("turn_kept", 32'(turn), 32'd1);
        doMove(4'd9);
        @(negedge clk);
        checkOutput("err_range", 32'(mv_err), 32'd1);

        // Legal move then a held (illegal) request across the scan
        doMove(4'd0);
        repeat (12) applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        waitIdle();

        // new_game mid-scan together with a move request
        doMove(4'd8);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ng_board", 32'(board), 32'd0);
        checkOutput("ng_status", 32'(status), 32'd0);
        checkOutput("ng_turn", 32'(turn), 32'(FP));
        checkOutput("ng_ack", 32'(mv_ack), 32'd0);
        checkOutput("ng_err", 32'(mv_err), 32'd0);
`ifdef TTT_MOVE_CNT_EN
        checkOutput("ng_move_cnt", 32'(move_cnt), 32'd0);
`endif

        // X wins the top row
        playSeq(seq_win, 5);
        checkOutput("xwin_status", 32'(status), 32'd1);
        checkOutput("mdl_xwin", 32'(mdl_status), 32'd1);
        doMove(4'd5);
        @(negedge clk);
        checkOutput("err_over", 32'(mv_err), 32'd1);
        newGame();

        // Full board with no line
        playSeq(seq_draw, 9);
        checkOutput("draw_status", 32'(status), 32'd3);
        checkOutput("mdl_draw", 32'(mdl_status), 32'd3);
        newGame();

        // Ninth move completes the 0-4-8 diagonal for X
        playSeq(seq_nine, 9);
        checkOutput("nine_win_status", 32'(status), 32'd1);
        checkOutput("mdl_nine_win", 32'(mdl_status), 32'd1);
        newGame();

        // Random play with occasional clears and resets
        for (int i = 0; i < 4000; i++) begin
            logic v, ng, r;
            logic [3:0] c;
            v  = ($urandom_range(0, 9) < 6);
            c  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ng = ($urandom_range(0, 199) == 0);
            r  = ($urandom_range(0, 399) == 0);
            applyStimulus(v, c, ng, r);
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
